// File: rtl/mac_ctrl_if.sv
// Stream and array-side bus of the MAC array sequencer.
// The master modport is the controller's view; slave is the producer/array side.
interface mac_ctrl_if #(
  parameter int unsigned DW     = 8,
  parameter int unsigned CW     = 19,
  parameter int unsigned ROW    = 8,
  parameter int unsigned COLUMN = 6
);
  logic [COLUMN*DW-1:0] w_in;
  logic                 w_valid;
  logic                 w_ready;
  logic [ROW*DW-1:0]    act_in;
  logic                 act_valid;
  logic                 act_ready;
  logic [COLUMN*DW-1:0] mac_w;
  logic [ROW-1:0]       mac_w_en;
  logic [ROW*DW-1:0]    mac_m_data;
  logic [COLUMN*CW-1:0] mac_ci;
  logic                 out_valid;
  logic                 out_first;
  logic                 out_last;

  modport master (
    input  w_in, w_valid, act_in, act_valid,
    output w_ready, act_ready, mac_w, mac_w_en, mac_m_data, mac_ci,
    output out_valid, out_first, out_last
  );

  modport slave (
    output w_in, w_valid, act_in, act_valid,
    input  w_ready, act_ready, mac_w, mac_w_en, mac_m_data, mac_ci,
    input  out_valid, out_first, out_last
  );
endinterface

// File: rtl/mac_ctrl.sv
// Sequencer for the ROW x COLUMN MAC array: weight load, activation streaming,
// bias hold and the valid/first/last sideband aligned to the array output.
module mac_ctrl #(
  parameter int unsigned DW     = 8,
  parameter int unsigned CW     = 19,
  parameter int unsigned ROW    = 8,
  parameter int unsigned COLUMN = 6,
  parameter int unsigned LAT    = 8,
  parameter int unsigned LW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cfg_load_w,
  input  logic [LW-1:0]        cfg_len,
  input  logic [COLUMN*CW-1:0] cfg_bias,
  output logic                 busy,
  output logic                 done,
  mac_ctrl_if.master           bus
);

  localparam int unsigned RowCntW   = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unsigned DrainCntW = $clog2(LAT + 1);
  localparam logic [RowCntW-1:0]   RowMax   = RowCntW'(ROW - 1);
  localparam logic [DrainCntW-1:0] DrainMax = DrainCntW'(LAT);

  typedef enum logic [1:0] {StIdle, StLoad, StComp, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [LW-1:0]          len_q;
  logic [RowCntW-1:0]     row_cnt_q;
  logic [LW-1:0]          act_cnt_q;
  logic [DrainCntW-1:0]   drain_cnt_q;
  logic [COLUMN*DW-1:0]   mac_w_q;
  logic [ROW-1:0]         mac_w_en_q;
  logic [ROW*DW-1:0]      m_data_q;
  logic [COLUMN*CW-1:0]   ci_q;
  logic                   done_q;
  // Token bits are {valid, first, last}; tok_q is aligned with mac_m_data.
  logic [2:0]             tok_q;
  logic [2:0]             sb_q [LAT];

  logic                   w_ready, act_ready, w_hs, act_hs;
  logic [LW:0]            act_cnt_inc;
  logic [ROW-1:0]         row_onehot;

  assign w_ready     = (state_q == StLoad);
  assign act_ready   = (state_q == StComp) && (act_cnt_q < len_q);
  assign w_hs        = bus.w_valid && w_ready;
  assign act_hs      = bus.act_valid && act_ready;
  assign act_cnt_inc = {1'b0, act_cnt_q} + {{LW{1'b0}}, act_hs};
  assign row_onehot  = ROW'(1) << row_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = cfg_load_w ? StLoad : StComp;
      StLoad:  if (w_hs && (row_cnt_q == RowMax)) state_d = StComp;
      // Leaves on the last handshake, or immediately when the job is empty.
      StComp:  if (act_cnt_inc == {1'b0, len_q}) state_d = StDrain;
      StDrain: if (drain_cnt_q == DrainMax) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      row_cnt_q   <= '0;
      act_cnt_q   <= '0;
      drain_cnt_q <= '0;
      mac_w_q     <= '0;
      mac_w_en_q  <= '0;
      m_data_q    <= '0;
      ci_q        <= '0;
      done_q      <= 1'b0;
      tok_q       <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && start) begin
        len_q <= cfg_len;
        ci_q  <= cfg_bias;
      end
      if (w_hs) begin
        mac_w_q   <= bus.w_in;
        row_cnt_q <= (row_cnt_q == RowMax) ? '0 : row_cnt_q + 1'b1;
      end
      mac_w_en_q  <= w_hs ? row_onehot : '0;
      act_cnt_q   <= (state_q == StComp) ? act_cnt_inc[LW-1:0] : '0;
      drain_cnt_q <= ((state_q == StDrain) && (state_d == StDrain)) ? drain_cnt_q + 1'b1 : '0;
      m_data_q    <= act_hs ? bus.act_in : '0;
      tok_q       <= {act_hs,
                      act_hs && (act_cnt_q == '0),
                      act_hs && (act_cnt_q == len_q - LW'(1))};
      done_q      <= (state_q == StDrain) && (state_d == StIdle);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= tok_q;
      for (int i = 1; i < int'(LAT); i++) sb_q[i] <= sb_q[i-1];
    end
  end

  assign bus.w_ready    = w_ready;
  assign bus.act_ready  = act_ready;
  assign bus.mac_w      = mac_w_q;
  assign bus.mac_w_en   = mac_w_en_q;
  assign bus.mac_m_data = m_data_q;
  assign bus.mac_ci     = ci_q;
  assign bus.out_valid  = sb_q[LAT-1][2];
  assign bus.out_first  = sb_q[LAT-1][1];
  assign bus.out_last   = sb_q[LAT-1][0];
  assign busy           = (state_q != StIdle);
  assign done           = done_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// Bench for mac_ctrl: directed and random jobs checked cycle by cycle against
// a schedule computed from handshake timing rules.
module tb_mac_ctrl;
  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = 19;
  localparam int unsigned ROW    = 8;
  localparam int unsigned COLUMN = 6;
  localparam int unsigned LAT    = 8;
  localparam int unsigned LW     = 16;
  localparam int          MAXC   = 160;

  logic                 clk = 1'b0;
  logic                 rst, start, cfg_load_w;
  logic [LW-1:0]        cfg_len;
  logic [COLUMN*CW-1:0] cfg_bias;
  logic                 busy, done;

  mac_ctrl_if #(.DW(DW), .CW(CW), .ROW(ROW), .COLUMN(COLUMN)) bus ();

  mac_ctrl #(
    .DW(DW), .CW(CW), .ROW(ROW), .COLUMN(COLUMN), .LAT(LAT), .LW(LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_load_w (cfg_load_w),
    .cfg_len    (cfg_len),
    .cfg_bias   (cfg_bias),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int                   checks = 0;
  int                   errors = 0;
  int                   job_id = 0;
  int                   done_cyc, done_cnt;
  logic [ROW-1:0]       first_en;
  logic [COLUMN*DW-1:0] prev_w;
  logic [COLUMN*CW-1:0] prev_ci;

  task automatic chk(input string tag, input int cyc, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s job=%0d cyc=%0d observed=%0h expected=%0h", tag, job_id, cyc, obs, exp);
    end
  endtask

  function automatic logic [COLUMN*CW-1:0] rand_bias();
    logic [COLUMN*CW-1:0] b;
    for (int i = 0; i < int'(COLUMN); i++) b[i*CW +: CW] = CW'($urandom());
    return b;
  endfunction

  // 0: always valid, 1: valid on odd cycles, 2: random (forced on late to bound the job)
  function automatic logic pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 1;
    return (cyc > 60) || ($urandom_range(0, 3) != 0);
  endfunction

  task automatic run_job(input bit load, input int len, input int wmode, input int amode,
                         input int bs_cyc, input int rst_cyc);
    logic                 wv [MAXC];
    logic                 av [MAXC];
    logic [COLUMN*DW-1:0] wd [MAXC];
    logic [ROW*DW-1:0]    ad [MAXC];
    int                   whs[$];
    int                   ahs[$];
    int                   c, comp_start, drain_start, done_c, ncyc, last_w, last_a;
    logic [COLUMN*CW-1:0] bias;
    logic [COLUMN*DW-1:0] e_w;
    logic [ROW-1:0]       e_wen;
    logic [ROW*DW-1:0]    e_md;
    logic [COLUMN*CW-1:0] e_ci;
    logic                 e_wr, e_ar, e_ov, e_of, e_ol, e_busy, e_done;

    job_id++;
    bias = rand_bias();
    for (int i = 0; i < MAXC; i++) begin
      wv[i] = pat(wmode, i);
      av[i] = pat(amode, i);
      wd[i] = (COLUMN*DW)'({$urandom(), $urandom()});
      ad[i] = (ROW*DW)'({$urandom(), $urandom()});
    end
    // k-th weight/activation lands on the k-th valid cycle once its phase is open.
    c = 1;
    if (load) begin
      for (int k = 0; k < int'(ROW); k++) begin
        while (!wv[c]) c++;
        whs.push_back(c);
        c++;
      end
    end
    last_w     = load ? whs[ROW-1] : -1;
    comp_start = load ? last_w + 1 : 1;
    c = comp_start;
    for (int k = 0; k < len; k++) begin
      while (!av[c]) c++;
      ahs.push_back(c);
      c++;
    end
    last_a      = (len > 0) ? ahs[len-1] : -1;
    drain_start = (len > 0) ? last_a + 1 : comp_start + 1;
    done_c      = drain_start + int'(LAT) + 1;
    ncyc        = (rst_cyc >= 0) ? rst_cyc + int'(LAT) + 6 : done_c + 3;
    done_cyc = -1;
    done_cnt = 0;
    first_en = '0;

    for (int cy = 0; cy < ncyc; cy++) begin
      @(negedge clk);
      e_wen = '0;
      e_w   = prev_w;
      for (int k = 0; k < whs.size(); k++) begin
        if (whs[k] == cy - 1) e_wen = ROW'(1) << k;
        if (whs[k] <= cy - 1) e_w = wd[whs[k]];
      end
      e_md = '0; e_ov = 1'b0; e_of = 1'b0; e_ol = 1'b0;
      for (int k = 0; k < ahs.size(); k++) begin
        if (ahs[k] == cy - 1) e_md = ad[ahs[k]];
        if (ahs[k] == cy - 1 - int'(LAT)) begin
          e_ov = 1'b1;
          e_of = (k == 0);
          e_ol = (k == len - 1);
        end
      end
      e_wr   = (cy >= 1) && (cy <= last_w);
      e_ar   = (cy >= comp_start) && (cy <= last_a);
      e_busy = (cy >= 1) && (cy < done_c);
      e_done = (cy == done_c);
      e_ci   = (cy >= 1) ? bias : prev_ci;
      if (rst_cyc >= 0 && cy > rst_cyc) begin
        e_w = '0; e_wen = '0; e_md = '0; e_ov = 1'b0; e_of = 1'b0; e_ol = 1'b0;
        e_wr = 1'b0; e_ar = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ci = '0;
      end
      chk("w_ready", cy, 128'(bus.w_ready), 128'(e_wr));
      chk("act_ready", cy, 128'(bus.act_ready), 128'(e_ar));
      chk("mac_w", cy, 128'(bus.mac_w), 128'(e_w));
      chk("mac_w_en", cy, 128'(bus.mac_w_en), 128'(e_wen));
      chk("mac_m_data", cy, 128'(bus.mac_m_data), 128'(e_md));
      chk("mac_ci", cy, 128'(bus.mac_ci), 128'(e_ci));
      chk("out_valid", cy, 128'(bus.out_valid), 128'(e_ov));
      chk("out_first", cy, 128'(bus.out_first), 128'(e_of));
      chk("out_last", cy, 128'(bus.out_last), 128'(e_ol));
      chk("busy", cy, 128'(busy), 128'(e_busy));
      chk("done", cy, 128'(done), 128'(e_done));
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cy;
      end
      if (first_en == '0 && bus.mac_w_en != '0) first_en = bus.mac_w_en;

      rst   = (cy == rst_cyc);
      start = (cy == 0) || (cy == bs_cyc);
      if (cy == 0) begin
        cfg_load_w = load;
        cfg_len    = LW'(len);
        cfg_bias   = bias;
      end else begin
        cfg_load_w = 1'($urandom());
        cfg_len    = LW'($urandom());
        cfg_bias   = rand_bias();
      end
      bus.w_valid   = wv[cy];
      bus.w_in      = wd[cy];
      bus.act_valid = av[cy];
      bus.act_in    = ad[cy];
    end

    if (rst_cyc >= 0) begin
      prev_w  = '0;
      prev_ci = '0;
    end else begin
      if (load) prev_w = wd[last_w];
      prev_ci = bias;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_load_w = 1'b0; cfg_len = '0; cfg_bias = '0;
    bus.w_valid = 1'b0; bus.w_in = '0; bus.act_valid = 1'b0; bus.act_in = '0;
    prev_w = '0; prev_ci = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_w_en", 0, 128'(bus.mac_w_en), 128'(0));
    chk("rst_m_data", 0, 128'(bus.mac_m_data), 128'(0));
    chk("rst_ci", 0, 128'(bus.mac_ci), 128'(0));
    chk("rst_out_valid", 0, 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 0, 128'(busy), 128'(0));
    chk("rst_ready", 0, 128'({bus.w_ready, bus.act_ready}), 128'(0));

    // Full job, all valids high.
    run_job(1'b1, 4, 0, 0, -1, -1);
    chk("full_done_cycle", 0, 128'(done_cyc), 128'(22));
    // Stalls on both streams.
    run_job(1'b1, 5, 1, 1, -1, -1);
    // Reuse resident weights.
    run_job(1'b0, 2, 0, 0, -1, -1);
    // Empty job with reload.
    run_job(1'b1, 0, 0, 0, -1, -1);
    chk("len0_done_count", 0, 128'(done_cnt), 128'(1));
    // Start with new bias while busy.
    run_job(1'b0, 6, 0, 2, 3, -1);
    chk("busy_start_dones", 0, 128'(done_cnt), 128'(1));
    // Reset in LOAD after three weight beats, then a fresh job.
    run_job(1'b1, 4, 0, 0, -1, 4);
    chk("abort_no_done", 0, 128'(done_cnt), 128'(0));
    run_job(1'b1, 3, 0, 0, -1, -1);
    chk("fresh_first_strobe", 0, 128'(first_en), 128'(1));
    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 9)), 2, 2, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Sequencer for the ROW×COLUMN MAC array in the CONV datapath. It loads one weight vector per array row through a one-hot `w_en` strobe and streams activation vectors into `mac_m_data`. It also generates the `valid`/`first`/`last` sideband the array itself lacks, aligned to `mac_s_data`, and holds the bias vector on `ci` for the duration of a job.

## Interface
- `DW`, 8: activation/weight element width.
- `CW`, 19: partial-sum width per column.
- `ROW`, 8: array rows (weight-enable bits, activation elements).
- `COLUMN`, 6: array columns.
- `LAT`, 8: array latency, in cycles, from `mac_m_data` to the matching `mac_s_data`; must be ≥1.
- `LW`, 16: width of the job-length field.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job start pulse; ignored unless in IDLE.
- `cfg_load_w`  in  1  1 = reload all ROW weight vectors before compute; 0 = reuse resident weights.
- `cfg_len`  in  LW  number of activation vectors in the job.
- `cfg_bias`  in  COLUMN*CW  per-column bias, sampled at `start`.
- `w_in`  in  COLUMN*DW  weight vector stream.
- `w_valid` / `w_ready`  in / out  1  weight handshake.
- `act_in`  in  ROW*DW  activation vector stream.
- `act_valid` / `act_ready`  in / out  1  activation handshake.
- `mac_w`  out  COLUMN*DW  weight bus to the array.
- `mac_w_en`  out  ROW  one-hot row weight-load strobe.
- `mac_m_data`  out  ROW*DW  activation bus to the array.
- `mac_ci`  out  COLUMN*CW  carry-in (bias) to row 0.
- `out_valid`, `out_first`, `out_last`  out  1 each  sideband aligned with `mac_s_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job completion.

## Operation
The controller is a four-state FSM: IDLE, LOAD, COMP, DRAIN.

IDLE:
- On `start`, latch `cfg_len` into `len_r` and `cfg_bias` into `mac_ci`.
- Next state is LOAD if `cfg_load_w`=1, otherwise COMP.

LOAD:
- `w_ready`=1.
- Each handshake (`w_valid`&`w_ready`) registers `w_in` into `mac_w` and sets `mac_w_en` to one-hot bit `row_cnt` for exactly one cycle.
- `row_cnt` counts 0..ROW-1.
- The handshake at `row_cnt`=ROW-1 clears `row_cnt` and moves to COMP.
- `mac_w` holds its value between beats.
- `mac_w_en`=0 on every cycle that follows a non-handshake cycle.

COMP:
- `act_ready` = (`act_cnt` < `len_r`).
- Each handshake registers `act_in` into `mac_m_data` and pushes a token into the LAT-deep sideband shift register:
  - valid=1;
  - first = (`act_cnt`==0);
  - last = (`act_cnt`==`len_r`-1).
- A non-handshake cycle drives `mac_m_data`=0 and pushes valid=0, first=0, last=0.
- When `act_cnt` reaches `len_r` (this includes `len_r`=0 on entry), move to DRAIN. `act_cnt` is cleared on entry to COMP.

DRAIN:
- `act_ready`=0 and `mac_m_data`=0; bubbles are pushed into the sideband pipe.
- `drain_cnt` counts LAT+1 cycles, then the FSM moves to IDLE and pulses `done` in the IDLE-entry cycle.

Rules that hold in all states:
- `mac_ci` is constant from the cycle after `start` until the next accepted `start`.
- `w_ready` and `act_ready` are never both high.
- `out_valid`/`out_first`/`out_last` are the LAT-stage delayed tokens. There is no output backpressure: the consumer is always ready.
- `cfg_len`=0: no activation is accepted, no `out_valid`, and `done` still pulses.
- `start` while `busy` is ignored; no configuration is re-latched.

Reset:
- Every output is 0 and the state is IDLE.
- Every counter and sideband stage is cleared.
- A reset mid-job aborts it with no `done` pulse.

## Timing
- Weight beat handshaken at cycle t: `mac_w` and `mac_w_en` are valid at t+1.
- Activation handshaken at cycle t: `mac_m_data` is valid at t+1, and the matching `out_valid` is at t+1+LAT.
- Back-to-back handshakes are supported: one weight or one activation per cycle.
- Fastest job with reload: 1 (IDLE→LOAD) + ROW + `len` + LAT+1 cycles from `start` to `done`.
- LOAD→COMP is registered. `act_ready` first rises in the cycle after the last weight handshake, so the last weight reaches the array before the first activation.
- `done` rises no earlier than the cycle after the last `out_valid`.
- `busy` rises the cycle after `start` and falls in the same cycle `done` rises.

## Test plan
- **Full job:** ROW=8, LAT=8, `cfg_load_w`=1, `cfg_len`=4, `w_valid` and `act_valid` held high.
  - Required: `mac_w_en` = 01,02,04,…,80 on 8 consecutive cycles.
  - Required: `act_ready` high for 4 cycles, then `out_valid` high for 4 cycles with `out_first` on the 1st and `out_last` on the 4th.
  - Required: `done` 1+8+4+9 = 22 cycles after `start`.
- **Stalls:** toggle `w_valid` and `act_valid` every other cycle.
  - Required: `mac_w_en` fires only on handshake cycles, still 8 one-hot strobes in row order.
  - Required: `out_valid` pattern equals the input handshake pattern delayed by LAT+1, with `mac_m_data`=0 in the gaps.
- **Reuse weights:** `cfg_load_w`=0, `cfg_len`=2.
  - Required: `w_ready` never asserts, `mac_w_en` stays 0, and `act_ready` is high the cycle after `start`.
- **`cfg_len`=0 with `cfg_load_w`=1:** 8 weight beats.
  - Required: no `act_ready`, no `out_valid`, and `done` after DRAIN.
- **Busy start:** pulse `start` with new `cfg_bias` during COMP.
  - Required: it is ignored; `mac_ci` is unchanged and only one `done` pulses.
- **Mid-job reset:** assert `rst` in LOAD after 3 weight beats, then run a fresh job.
  - Required: all outputs 0 the cycle after reset and no `done` for the aborted job.
  - Required: the fresh job's first strobe is `mac_w_en`=01.
